pool_core_mc: RTL and testbench



---
 rtl/pool_core_mc.sv | 150 +++++++++++++++
 tb/tb_pool_core_mc.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_core_mc.sv
// Multi-channel max / rounded-average pooling core with a registered reduction tree and valid/ready backpressure.
// Optional POOL_CORE_MC_ARGMAX_EN adds out_idx, the per-channel element index of the maximum.
module pool_core_mc #(
    parameter int DATA_WIDTH  = 8,
    parameter int WIN_SIZE    = 3,
    parameter int CH_NUM      = 4,
    parameter int RECIP_SHIFT = 16
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic                                          in_vld,
    output logic                                          in_rdy,
    input  logic                                          mode,
    input  logic [CH_NUM*WIN_SIZE*WIN_SIZE*DATA_WIDTH-1:0] din,
    output logic                                          out_vld,
`ifdef POOL_CORE_MC_ARGMAX_EN
    output logic [CH_NUM*$clog2(WIN_SIZE*WIN_SIZE)-1:0]   out_idx,
`endif
    input  logic                                          out_rdy,
    output logic [CH_NUM*DATA_WIDTH-1:0]                  dout
);

    localparam int VAR_NUM = WIN_SIZE * WIN_SIZE;
    localparam int T       = $clog2(VAR_NUM);
    localparam int SW      = DATA_WIDTH + T;
    localparam int PW      = SW + RECIP_SHIFT + 2;
    localparam int RECIP   = ((1 << RECIP_SHIFT) + VAR_NUM - 1) / VAR_NUM;

    localparam logic signed [PW-1:0] RECIP_W = PW'(RECIP);
    localparam logic signed [PW-1:0] HALF    = PW'(1 << (RECIP_SHIFT - 1));
    localparam logic signed [PW-1:0] SAT_HI  = PW'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [PW-1:0] SAT_LO  = -PW'(1 << (DATA_WIDTH - 1));

    // Number of live elements at tree level t (level 0 is the raw window).
    function automatic int lvl_cnt(input int t);
        return (VAR_NUM + (1 << t) - 1) >> t;
    endfunction

    function automatic int clip(input int i);
        return (i < VAR_NUM) ? i : VAR_NUM - 1;
    endfunction

    logic signed [DATA_WIDTH-1:0] mx [CH_NUM][T+1][VAR_NUM];
    logic signed [SW-1:0]         sm [CH_NUM][T+1][VAR_NUM];
    logic [T:0]                   vld_p;
    logic [T:0]                   mode_p;
    logic                         en;
    logic signed [PW-1:0]         avg [CH_NUM];
    logic [CH_NUM*DATA_WIDTH-1:0] res_dout;
`ifdef POOL_CORE_MC_ARGMAX_EN
    logic [T-1:0]                 idx [CH_NUM][T+1][VAR_NUM];
    logic [CH_NUM*T-1:0]          res_idx;
`endif

    assign en     = !out_vld || out_rdy;
    assign in_rdy = en;

    always_comb begin
        res_dout = '0;
`ifdef POOL_CORE_MC_ARGMAX_EN
        res_idx  = '0;
`endif
        for (int c = 0; c < CH_NUM; c++) begin
            // Multiply by the reciprocal, round half up, floor via arithmetic shift.
            avg[c] = ((PW'(sm[c][T][0]) * RECIP_W) + HALF) >>> RECIP_SHIFT;
            if (!mode_p[T])
                res_dout[c*DATA_WIDTH +: DATA_WIDTH] = mx[c][T][0];
            else if (avg[c] > SAT_HI)
                res_dout[c*DATA_WIDTH +: DATA_WIDTH] = SAT_HI[DATA_WIDTH-1:0];
            else if (avg[c] < SAT_LO)
                res_dout[c*DATA_WIDTH +: DATA_WIDTH] = SAT_LO[DATA_WIDTH-1:0];
            else
                res_dout[c*DATA_WIDTH +: DATA_WIDTH] = avg[c][DATA_WIDTH-1:0];
`ifdef POOL_CORE_MC_ARGMAX_EN
            res_idx[c*T +: T] = mode_p[T] ? '0 : idx[c][T][0];
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p   <= '0;
            mode_p  <= '0;
            out_vld <= 1'b0;
            dout    <= '0;
            for (int c = 0; c < CH_NUM; c++)
                for (int t = 0; t <= T; t++)
                    for (int l = 0; l < VAR_NUM; l++) begin
                        mx[c][t][l] <= '0;
                        sm[c][t][l] <= '0;
`ifdef POOL_CORE_MC_ARGMAX_EN
                        idx[c][t][l] <= '0;
`endif
                    end
`ifdef POOL_CORE_MC_ARGMAX_EN
            out_idx <= '0;
`endif
        end else if (en) begin
            vld_p  <= {vld_p[T-1:0], in_vld};
            mode_p <= {mode_p[T-1:0], mode};
            for (int c = 0; c < CH_NUM; c++) begin
                for (int e = 0; e < VAR_NUM; e++) begin
                    mx[c][0][e] <= din[(c*VAR_NUM+e)*DATA_WIDTH +: DATA_WIDTH];
                    sm[c][0][e] <= SW'($signed(din[(c*VAR_NUM+e)*DATA_WIDTH +: DATA_WIDTH]));
`ifdef POOL_CORE_MC_ARGMAX_EN
                    idx[c][0][e] <= T'(e);
`endif
                end
                // Pair 2l with 2l+1; a trailing odd element passes through, dead slots hold zero.
                for (int t = 1; t <= T; t++)
                    for (int l = 0; l < VAR_NUM; l++) begin
                        if (2*l+1 < lvl_cnt(t-1)) begin
                            if (mx[c][t-1][clip(2*l)] >= mx[c][t-1][clip(2*l+1)]) begin
                                mx[c][t][l] <= mx[c][t-1][clip(2*l)];
`ifdef POOL_CORE_MC_ARGMAX_EN
                                idx[c][t][l] <= idx[c][t-1][clip(2*l)];
`endif
                            end else begin
                                mx[c][t][l] <= mx[c][t-1][clip(2*l+1)];
`ifdef POOL_CORE_MC_ARGMAX_EN
                                idx[c][t][l] <= idx[c][t-1][clip(2*l+1)];
`endif
                            end
                            sm[c][t][l] <= sm[c][t-1][clip(2*l)] + sm[c][t-1][clip(2*l+1)];
                        end else if (2*l < lvl_cnt(t-1)) begin
                            mx[c][t][l] <= mx[c][t-1][clip(2*l)];
                            sm[c][t][l] <= sm[c][t-1][clip(2*l)];
`ifdef POOL_CORE_MC_ARGMAX_EN
                            idx[c][t][l] <= idx[c][t-1][clip(2*l)];
`endif
                        end else begin
                            mx[c][t][l] <= '0;
                            sm[c][t][l] <= '0;
`ifdef POOL_CORE_MC_ARGMAX_EN
                            idx[c][t][l] <= '0;
`endif
                        end
                    end
            end
            out_vld <= vld_p[T];
            if (vld_p[T]) begin
                dout <= res_dout;
`ifdef POOL_CORE_MC_ARGMAX_EN
                out_idx <= res_idx;
`endif
            end
        end
    end

endmodule

// File: tb/tb_pool_core_mc.sv
// Bench for pool_core_mc: directed spec scenarios plus randomized traffic against a scoreboard model.
// Checks out_idx as well when built with POOL_CORE_MC_ARGMAX_EN.
module tb_pool_core_mc;

    localparam int DW    = 8;
    localparam int WIN   = 3;
    localparam int CH    = 2;
    localparam int VN    = 9;
    localparam int IW    = 4;
    localparam int RS    = 16;
    localparam int RECIP = 7282;
    localparam int W     = CH*VN*DW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_vld = 1'b0;
    logic          in_rdy;
    logic          mode = 1'b0;
    logic [W-1:0]  din = '0;
    logic          out_vld;
    logic          out_rdy = 1'b1;
    logic [CH*DW-1:0] dout;
`ifdef POOL_CORE_MC_ARGMAX_EN
    logic [CH*IW-1:0] out_idx;
`endif

    always #5 clk = ~clk;

    pool_core_mc #(.DATA_WIDTH(DW), .WIN_SIZE(WIN), .CH_NUM(CH), .RECIP_SHIFT(RS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .mode    (mode),
        .din     (din),
        .out_vld (out_vld),
`ifdef POOL_CORE_MC_ARGMAX_EN
        .out_idx (out_idx),
`endif
        .out_rdy (out_rdy),
        .dout    (dout)
    );

    int total = 0;
    int bad   = 0;
    logic [CH*DW-1:0] exp_q [$];
    logic [CH*IW-1:0] expi_q [$];
    logic             acc;
    logic             prev_stall = 1'b0;
    logic [CH*DW-1:0] prev_dout = '0;
    int               n_out = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int el(input logic [W-1:0] d, input int c, input int e);
        logic signed [DW-1:0] v;
        v = d[(c*VN+e)*DW +: DW];
        return int'(v);
    endfunction

    function automatic logic [CH*DW-1:0] ref_dout(input logic [W-1:0] d, input logic m);
        logic [CH*DW-1:0] r;
        longint s, a;
        int best;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            if (!m) begin
                best = el(d, c, 0);
                for (int e = 1; e < VN; e++) if (el(d, c, e) > best) best = el(d, c, e);
                r[c*DW +: DW] = DW'(best);
            end else begin
                s = 0;
                for (int e = 0; e < VN; e++) s += el(d, c, e);
                a = (s * RECIP + (64'sd1 << (RS-1))) >>> RS;
                if (a > 127) a = 127;
                if (a < -128) a = -128;
                r[c*DW +: DW] = DW'(a);
            end
        end
        return r;
    endfunction

    function automatic logic [CH*IW-1:0] ref_idx(input logic [W-1:0] d, input logic m);
        logic [CH*IW-1:0] r;
        int best, bi;
        r = '0;
        if (!m)
            for (int c = 0; c < CH; c++) begin
                best = el(d, c, 0);
                bi = 0;
                for (int e = 1; e < VN; e++)
                    if (el(d, c, e) > best) begin best = el(d, c, e); bi = e; end
                r[c*IW +: IW] = IW'(bi);
            end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_win();
        logic [W-1:0] r;
        for (int i = 0; i < CH*VN; i++)
            case ($urandom_range(0, 3))
                0: r[i*DW +: DW] = 8'h80;
                1: r[i*DW +: DW] = 8'h7f;
                default: r[i*DW +: DW] = DW'($urandom);
            endcase
        return r;
    endfunction

    function automatic logic [W-1:0] mkwin(input int a[VN], input int b[VN]);
        logic [W-1:0] r;
        for (int e = 0; e < VN; e++) begin
            r[e*DW +: DW]      = DW'(a[e]);
            r[(VN+e)*DW +: DW] = DW'(b[e]);
        end
        return r;
    endfunction

    // One clock: sample at negedge, score, then return just after the next posedge.
    task automatic step();
        logic [CH*DW-1:0] e;
        logic [CH*IW-1:0] ei;
        @(negedge clk);
        acc = in_vld && in_rdy;
        if (prev_stall) begin
            check("stall_vld", int'(out_vld), 1);
            check("stall_dout", int'(dout), int'(prev_dout));
        end
        if (out_vld && !out_rdy) check("in_rdy_stall", int'(in_rdy), 0);
        if (acc) begin
            exp_q.push_back(ref_dout(din, mode));
            expi_q.push_back(ref_idx(din, mode));
        end
        if (out_vld && out_rdy) begin
            n_out++;
            if (exp_q.size() == 0) check("spurious_out", int'(out_vld), 0);
            else begin
                e  = exp_q.pop_front();
                ei = expi_q.pop_front();
                check("dout", int'(dout), int'(e));
`ifdef POOL_CORE_MC_ARGMAX_EN
                check("out_idx", int'(out_idx), int'(ei));
`endif
            end
        end
        prev_stall = out_vld && !out_rdy;
        prev_dout  = dout;
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [W-1:0] d, input logic m, output int lat);
        din = d; mode = m; in_vld = 1'b1; out_rdy = 1'b1;
        step();
        in_vld = 1'b0;
        lat = 0;
        while (!out_vld && lat < 20) begin
            step();
            lat++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wa[VN], wb[VN];
        int lat, k, cyc, n0;
        logic [W-1:0] cur;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_vld", int'(out_vld), 0);
        check("rst_dout", int'(dout), 0);
        reset_n = 1'b1;
        #1;
        check("rst_in_rdy", int'(in_rdy), 1);
        @(posedge clk); #1;

        wa = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        foreach (wb[i]) wb[i] = -128;
        send_one(mkwin(wa, wb), 1'b0, lat);
        check("max_latency", lat, 5);
        check("max_ch0", int'($signed(dout[7:0])), 9);
        check("max_ch1", int'($signed(dout[15:8])), -128);
`ifdef POOL_CORE_MC_ARGMAX_EN
        check("max_idx0", int'(out_idx[3:0]), 8);
        check("max_idx1", int'(out_idx[7:4]), 0);
`endif
        step();

        foreach (wb[i]) wb[i] = -1;
        send_one(mkwin(wa, wb), 1'b1, lat);
        check("avg_latency", lat, 5);
        check("avg_ch0", int'($signed(dout[7:0])), 5);
        check("avg_ch1", int'($signed(dout[15:8])), -1);
        step();

        foreach (wa[i]) wa[i] = 127;
        foreach (wb[i]) wb[i] = -128;
        send_one(mkwin(wa, wb), 1'b1, lat);
        check("avgx_ch0", int'($signed(dout[7:0])), 127);
        check("avgx_ch1", int'($signed(dout[15:8])), -128);
`ifdef POOL_CORE_MC_ARGMAX_EN
        check("avgx_idx", int'(out_idx), 0);
`endif
        step();

        wa = '{-5, -3, -3, -7, -3, -9, -10, -4, -6};
        foreach (wb[i]) wb[i] = 0;
        send_one(mkwin(wa, wb), 1'b0, lat);
        check("tie_ch0", int'($signed(dout[7:0])), -3);
`ifdef POOL_CORE_MC_ARGMAX_EN
        check("tie_idx0", int'(out_idx[3:0]), 1);
`endif
        step();

        // 8 back-to-back windows with a 6-cycle downstream stall mid-stream.
        k = 0; cyc = 0; n0 = n_out; cur = rand_win();
        while ((k < 8 || exp_q.size() > 0) && cyc < 100) begin
            out_rdy = !(cyc >= 6 && cyc < 12);
            in_vld  = (k < 8);
            mode    = k[0];
            din     = cur;
            step();
            if (acc) begin k++; cur = rand_win(); end
            cyc++;
        end
        in_vld = 1'b0; out_rdy = 1'b1;
        check("bp_count", n_out - n0, 8);
        check("bp_drained", exp_q.size(), 0);

        // Random traffic with random backpressure.
        cur = rand_win();
        in_vld = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!in_vld) begin
                in_vld = ($urandom_range(0, 3) != 0);
                mode   = 1'($urandom);
                din    = cur;
            end
            out_rdy = ($urandom_range(0, 2) != 0);
            step();
            if (acc) begin
                cur    = rand_win();
                in_vld = ($urandom_range(0, 3) != 0);
                mode   = 1'($urandom);
                din    = cur;
            end
        end
        in_vld = 1'b0; out_rdy = 1'b1;
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) step();
        check("rand_drained", exp_q.size(), 0);

        // Reset with three windows in flight and one result held at the output.
        wa = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        for (int i = 0; i < 3; i++) begin
            din = (i == 0) ? mkwin(wa, wb) : rand_win();
            mode = 1'b0; in_vld = 1'b1; out_rdy = 1'b1;
            step();
        end
        in_vld = 1'b0; out_rdy = 1'b0;
        for (int i = 0; i < 20 && !out_vld; i++) step();
        check("pre_rst_vld", int'(out_vld), 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_vld", int'(out_vld), 0);
        check("mid_rst_dout", int'(dout), 0);
        exp_q.delete(); expi_q.delete(); prev_stall = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        out_rdy = 1'b1;
        n0 = n_out;
        repeat (10) step();
        check("post_rst_quiet", n_out - n0, 0);
        foreach (wa[i]) wa[i] = 10 + i;
        send_one(mkwin(wa, wb), 1'b1, lat);
        check("post_rst_latency", lat, 5);
        check("post_rst_ch0", int'($signed(dout[7:0])), 14);
        step();
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
